// File: rtl/input_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_cond_pkg
// Description : Shared debouncer state encoding and counter sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package input_cond_pkg;

  typedef enum logic [0:0] {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } state_t;

  // A single-cycle debounce window still needs a 1-bit counter to compare against.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

endpackage : input_cond_pkg
`default_nettype wire

// File: rtl/input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner_if
// Description : Raw pad inputs in, debounced word and change reporting out.
// Revision    : 1.0 - initial release
// ============================================================================
interface input_conditioner_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] RawIn;
  logic             Hold;
  logic             ClrFlag;
  logic [WIDTH-1:0] DataOut;
  logic             Changed;
  logic [WIDTH-1:0] ChangeMask;
  logic             ChangeFlag;

  modport master (
    output RawIn,
    output Hold,
    output ClrFlag,
    input  DataOut,
    input  Changed,
    input  ChangeMask,
    input  ChangeFlag
  );

  modport slave (
    input  RawIn,
    input  Hold,
    input  ClrFlag,
    output DataOut,
    output Changed,
    output ChangeMask,
    output ChangeFlag
  );

endinterface : input_conditioner_if
`default_nettype wire

// File: rtl/in_sync.sv
`default_nettype none
// ============================================================================
// Module      : in_sync
// Description : WIDTH x SYNC_STAGES flop chain bringing async inputs into clk.
// Revision    : 1.0 - initial release
// ============================================================================
module in_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] i_async,
  output      logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_sync = r_stage[SYNC_STAGES-1];

endmodule : in_sync
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : Synchronizes and whole-word debounces board inputs for the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input_conditioner_if.slave bus
);

  localparam int            CW        = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] c_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] w_sync;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cand;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mask;
  logic             r_changed;
  logic             r_flag;

  logic             w_sync_ne_data;
  logic             w_sync_ne_cand;
  logic             w_cnt_full;
  logic             w_cand_load;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_commit;

  in_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bus.RawIn),
    .o_sync  (w_sync)
  );

  assign w_sync_ne_data = (w_sync != r_data);
  assign w_sync_ne_cand = (w_sync != r_cand);
  assign w_cnt_full     = (r_count == c_CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STABLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      STABLE: begin
        if (w_sync_ne_data) begin
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (w_sync_ne_cand) begin
          if (!w_sync_ne_data) begin
            w_state_nxt = STABLE;
          end
        end else if (w_cnt_full && !bus.Hold) begin
          w_state_nxt = STABLE;
        end
      end
      default: w_state_nxt = STABLE;
    endcase
  end

  // On a glitch back, SyncIn equals DataOut, so loading SyncIn restores the committed word.
  always_comb begin
    w_cand_load = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      STABLE: begin
        if (w_sync_ne_data) begin
          w_cand_load = 1'b1;
          w_cnt_clr   = 1'b1;
        end
      end
      SETTLE: begin
        if (w_sync_ne_cand) begin
          w_cand_load = 1'b1;
          w_cnt_clr   = w_sync_ne_data;
        end else if (w_cnt_full) begin
          w_commit = !bus.Hold;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: begin
        w_cand_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand  <= '0;
      r_count <= '0;
    end else begin
      if (w_cand_load) begin
        r_cand <= w_sync;
      end
      if (w_cnt_clr) begin
        r_count <= '0;
      end else if (w_cnt_inc) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  // A commit in the same cycle as ClrFlag leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_mask    <= '0;
      r_changed <= 1'b0;
      r_flag    <= 1'b0;
    end else begin
      r_changed <= w_commit;
      if (w_commit) begin
        r_data <= r_cand;
        r_mask <= r_data ^ r_cand;
        r_flag <= 1'b1;
      end else if (bus.ClrFlag) begin
        r_flag <= 1'b0;
      end
    end
  end

  assign bus.DataOut    = r_data;
  assign bus.ChangeMask = r_mask;
  assign bus.Changed    = r_changed;
  assign bus.ChangeFlag = r_flag;

endmodule : input_conditioner
`default_nettype wire
